gate_response_checker: RTL and testbench
========================================

GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 Parameter N_VECTORS, default 4, number of samples checked per run (legal range 1..255).
REQ-002 Parameter TIMEOUT, default 64, maximum idle cycles between accepted samples while running (legal range 1..65535).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-006 gate_sel  input  3  gate under check: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6-7 reserved.
REQ-007 smp_valid  input  1  sample offered this cycle.
REQ-008 smp_a, smp_b  input  1 each  stimulus applied to the gate.
REQ-009 smp_y  input  1  observed gate output.
REQ-010 smp_ready  output  1  checker accepts a sample this cycle.
REQ-011 busy  output  1  run in progress.
REQ-012 done  output  1  one-cycle pulse at end of run.
REQ-013 pass  output  1  verdict of last run, held until next start.
REQ-014 timeout  output  1  last run ended on timeout, held until next start.
REQ-015 err_count  output  4  mismatches in last/current run, saturating at 15.
REQ-016 cov_mask  output  4  bit {a,b} set once that input combination has been accepted.

Function
REQ-017 FSM states IDLE, RUN, REPORT; reset state IDLE.
REQ-018 IDLE -> RUN on start=1 with gate_sel 0..5; on start with reserved gate_sel, go to REPORT with err_count=15, pass=0.
REQ-019 Entry to RUN clears err_count, cov_mask, timeout, pass, sample counter and idle counter in the same edge; gate_sel is latched and later changes are ignored.
REQ-020 smp_ready = 1 only in RUN; a sample is accepted when smp_valid & smp_ready on a rising edge.
REQ-021 Each accepted sample: expected = f(gate_sel, smp_a, smp_b); mismatch increments err_count (saturate at 15); cov_mask[{smp_a,smp_b}] set; sample counter increments.
REQ-022 Idle counter resets on each accepted sample, increments on every other RUN cycle.
REQ-023 RUN -> REPORT on the edge accepting sample number N_VECTORS, or when idle counter reaches TIMEOUT (timeout=1); if both occur in the same cycle, the sample is counted and timeout=0.
REQ-024 REPORT lasts exactly one cycle: done=1, then -> IDLE; pass = (err_count==0) & (cov_mask==4'b1111) & ~timeout, registered and valid from the done cycle onward.
REQ-025 busy = 1 in RUN and REPORT; 0 in IDLE.
REQ-026 start asserted while in RUN or REPORT is ignored.
REQ-027 Latency: done is asserted the cycle after the final sample is accepted.

Reset
REQ-028 rst asserted at any time, including mid-run, forces IDLE immediately; smp_ready, busy, done, pass, timeout = 0; err_count = 0; cov_mask = 0; all counters = 0.
REQ-029 No done pulse is produced for a run aborted by reset.

Structure
REQ-030 Package gate_chk_pkg holds the gate_sel encoding constants and the FSM state type.
REQ-031 Sub-module gate_ref_model (combinational, inputs gate_sel, a, b; output expected) computes the reference function; the checker instantiates it once.

Verification
REQ-032 gate_sel=1 (OR), start, feed (0,0,0),(0,1,1),(1,0,1),(1,1,1) back to back -> done pulses 1 cycle after 4th sample, pass=1, err_count=0, cov_mask=1111.
REQ-033 gate_sel=1, feed the same stimulus with the AND gate's outputs (0,0,0,1) -> err_count=2, pass=0, cov_mask=1111.
REQ-034 gate_sel=4 (XOR), feed only (0,0,0) four times -> err_count=0, cov_mask=0001, pass=0.
REQ-035 Start, accept 2 samples, hold smp_valid=0 for TIMEOUT cycles -> timeout=1, done pulse, pass=0, err_count unchanged.
REQ-036 Assert rst after 2 accepted samples -> busy=0, err_count=0, cov_mask=0 immediately, no done pulse; new run completes normally.
REQ-037 start with gate_sel=7 -> single done pulse next cycle, err_count=15, pass=0.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared encodings for the gate response checker.
// Gate select codes, FSM state type and a legality helper.
package gate_chk_pkg;

  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_OR   = 3'd1;
  localparam logic [2:0] GATE_NAND = 3'd2;
  localparam logic [2:0] GATE_NOR  = 3'd3;
  localparam logic [2:0] GATE_XOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REPORT
  } state_t;

  function automatic logic gate_legal(
    input logic [2:0] g
  );
    return g <= GATE_XNOR;
  endfunction

endpackage

// File: rtl/gate_chk_ref_model.sv
// Reference truth function for the gate under check.
// Reserved selects produce 0; they never reach a run.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [2:0] gate_sel,
  input  logic       a,
  input  logic       b,
  output logic       expected
);

  always_comb begin
    expected = 1'b0;
    unique case (gate_sel)
      GATE_AND:  expected = a & b;
      GATE_OR:   expected = a | b;
      GATE_NAND: expected = ~(a & b);
      GATE_NOR:  expected = ~(a | b);
      GATE_XOR:  expected = a ^ b;
      GATE_XNOR: expected = ~(a ^ b);
      default:   expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_response_checker.sv
// Checks observed gate outputs against a reference over a run
// of samples, tracking errors, input coverage and idle timeout.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int N_VECTORS = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       smp_valid,
  input  logic       smp_a,
  input  logic       smp_b,
  input  logic       smp_y,
  output logic       smp_ready,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [3:0] err_count,
  output logic [3:0] cov_mask
);

  localparam logic [7:0]  LAST_SMP  = 8'(N_VECTORS - 1);
  localparam logic [15:0] LAST_IDLE = 16'(TIMEOUT - 1);

  state_t      state;
  logic [2:0]  gsel_q;
  logic [7:0]  smp_cnt;
  logic [15:0] idle_cnt;
  logic        expected;
  logic        accept;
  logic [3:0]  err_nxt;
  logic [3:0]  cov_nxt;

  gate_ref_model u_ref (
    .gate_sel (gsel_q),
    .a        (smp_a),
    .b        (smp_b),
    .expected (expected)
  );

  assign smp_ready = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == REPORT);
  assign accept    = smp_valid & smp_ready;

  // Next-state counters feed both the update and the verdict.
  always_comb begin
    err_nxt = err_count;
    if (expected != smp_y && err_count != 4'hF)
      err_nxt = err_count + 4'd1;
    cov_nxt = cov_mask | (4'b0001 << {smp_a, smp_b});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gsel_q    <= 3'd0;
      smp_cnt   <= 8'd0;
      idle_cnt  <= 16'd0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= 4'd0;
      cov_mask  <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            timeout  <= 1'b0;
            pass     <= 1'b0;
            cov_mask <= 4'd0;
            smp_cnt  <= 8'd0;
            idle_cnt <= 16'd0;
            if (gate_legal(gate_sel)) begin
              state     <= RUN;
              gsel_q    <= gate_sel;
              err_count <= 4'd0;
            end else begin
              state     <= REPORT;
              err_count <= 4'hF;
            end
          end
        end
        RUN: begin
          if (accept) begin
            err_count <= err_nxt;
            cov_mask  <= cov_nxt;
            idle_cnt  <= 16'd0;
            smp_cnt   <= smp_cnt + 8'd1;
            if (smp_cnt == LAST_SMP) begin
              state <= REPORT;
              pass  <= (err_nxt == 4'd0) && (cov_nxt == 4'hF);
            end
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
            if (idle_cnt == LAST_IDLE) begin
              state   <= REPORT;
              timeout <= 1'b1;
              pass    <= 1'b0;
            end
          end
        end
        REPORT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench: drivers queue expected run verdicts,
// a monitor checks them whenever done pulses.
module tb_gate_response_checker;

  localparam int TOUT = 8;

  typedef struct {
    int err;
    int cov;
    int pass;
    int to;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] gate_sel;
  logic       smp_valid;
  logic       smp_a;
  logic       smp_b;
  logic       smp_y;
  logic       smp_ready;
  logic       busy;
  logic       done;
  logic       pass;
  logic       timeout;
  logic [3:0] err_count;
  logic [3:0] cov_mask;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t q[$];
  exp_t e;

  gate_response_checker #(
    .N_VECTORS (4),
    .TIMEOUT   (TOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .gate_sel  (gate_sel),
    .smp_valid (smp_valid),
    .smp_a     (smp_a),
    .smp_b     (smp_b),
    .smp_y     (smp_y),
    .smp_ready (smp_ready),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .err_count (err_count),
    .cov_mask  (cov_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("err_count", int'(err_count), e.err);
        chk("cov_mask", int'(cov_mask), e.cov);
        chk("pass", int'(pass), e.pass);
        chk("timeout", int'(timeout), e.to);
      end
    end
  end

  task automatic push(input int er, input int cv, input int ps,
                      input int t, input int dc);
    exp_t x;
    x.err = er;
    x.cov = cv;
    x.pass = ps;
    x.to = t;
    x.cyc = dc;
    q.push_back(x);
  endtask

  task automatic start_run(input logic [2:0] g);
    gate_sel = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic smp(input logic a, input logic b, input logic y);
    smp_valid = 1'b1;
    smp_a = a;
    smp_b = b;
    smp_y = y;
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: got busy=1 after %0d cycles, expected 0", n);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    gate_sel = 3'd0;
    smp_valid = 1'b0;
    smp_a = 1'b0;
    smp_b = 1'b0;
    smp_y = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(smp_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_cov", int'(cov_mask), 0);

    // OR, correct responses
    start_run(3'd1);
    smp(0, 0, 0);
    smp(0, 1, 1);
    smp(1, 0, 1);
    push(0, 15, 1, 0, cyc + 1);
    smp(1, 1, 1);
    wait_idle();

    // OR checked against AND outputs
    start_run(3'd1);
    smp(0, 0, 0);
    smp(0, 1, 0);
    smp(1, 0, 0);
    push(2, 15, 0, 0, cyc + 1);
    smp(1, 1, 1);
    wait_idle();

    // XOR, one input combination only
    start_run(3'd4);
    smp(0, 0, 0);
    smp(0, 0, 0);
    smp(0, 0, 0);
    push(0, 1, 0, 0, cyc + 1);
    smp(0, 0, 0);
    wait_idle();

    // AND, two samples then idle until timeout
    start_run(3'd0);
    smp(1, 1, 1);
    push(1, 10, 0, 1, cyc + 1 + TOUT);
    smp(0, 1, 1);
    wait_idle();

    // NAND aborted by reset after two mismatching samples
    start_run(3'd2);
    smp(0, 0, 0);
    smp(1, 1, 1);
    chk("pre_abort_err", int'(err_count), 2);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(smp_ready), 0);
    chk("abort_err", int'(err_count), 0);
    chk("abort_cov", int'(cov_mask), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // NOR after abort
    start_run(3'd3);
    smp(0, 0, 1);
    smp(0, 1, 0);
    smp(1, 0, 0);
    push(0, 15, 1, 0, cyc + 1);
    smp(1, 1, 0);
    wait_idle();

    // Reserved gate select
    push(15, 0, 0, 0, cyc + 1);
    start_run(3'd7);
    wait_idle();

    // XNOR with a bubble; gate_sel and start change mid-run
    start_run(3'd5);
    gate_sel = 3'd0;
    smp(0, 0, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    smp(1, 1, 1);
    smp(0, 1, 0);
    push(0, 15, 1, 0, cyc + 1);
    smp(1, 0, 0);
    wait_idle();
    chk("pass_held", int'(pass), 1);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
